// File: rtl/writeback_arb_ctrl.sv
// LC-3 writeback: round-robin ALU/load write arbiter, 8x16 register file, NZP code.
// Define WB_BYPASS_EN to make VSR1/VSR2 write-through when a commit hits the read address.
module writeback_arb_ctrl #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [$clog2(NREGS)-1:0] alu_dr,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     alu_setcc,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [$clog2(NREGS)-1:0] mem_dr,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     mem_setcc,
    input  logic [$clog2(NREGS)-1:0] sr1,
    input  logic [$clog2(NREGS)-1:0] sr2,
    output logic [2:0]               psr,
    output logic [DATA_W-1:0]        VSR1,
    output logic [DATA_W-1:0]        VSR2
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    grant_t              r_last_grant;
    grant_t              w_last_next;
    logic [DATA_W-1:0]   r_rf [NREGS];
    logic [2:0]          r_psr;
    logic [DATA_W-1:0]   r_vsr1;
    logic [DATA_W-1:0]   r_vsr2;

    logic                w_grant_alu;
    logic                w_grant_mem;
    logic                w_wr_en;
    logic [AW-1:0]       w_wr_dr;
    logic [DATA_W-1:0]   w_wr_data;
    logic                w_wr_setcc;
    logic                w_n;
    logic                w_z;
    logic [2:0]          w_psr_next;
    logic [DATA_W-1:0]   w_rd1;
    logic [DATA_W-1:0]   w_rd2;

    // On a tie the source that did not win last time is granted.
    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_mem = 1'b0;
        if (!reset) begin
            if (alu_valid && (!mem_valid || r_last_grant == GRANT_MEM)) begin
                w_grant_alu = 1'b1;
            end else if (mem_valid) begin
                w_grant_mem = 1'b1;
            end
        end

        w_last_next = r_last_grant;
        if (w_grant_alu) begin
            w_last_next = GRANT_ALU;
        end else if (w_grant_mem) begin
            w_last_next = GRANT_MEM;
        end

        w_wr_en    = w_grant_alu | w_grant_mem;
        w_wr_dr    = w_grant_alu ? alu_dr    : mem_dr;
        w_wr_data  = w_grant_alu ? alu_data  : mem_data;
        w_wr_setcc = w_grant_alu ? alu_setcc : mem_setcc;

        w_n        = w_wr_data[DATA_W-1];
        w_z        = (w_wr_data == '0);
        w_psr_next = {w_n, w_z, !w_n && !w_z};

        w_rd1 = r_rf[sr1];
        w_rd2 = r_rf[sr2];
`ifdef WB_BYPASS_EN
        if (w_wr_en && w_wr_dr == sr1) begin
            w_rd1 = w_wr_data;
        end
        if (w_wr_en && w_wr_dr == sr2) begin
            w_rd2 = w_wr_data;
        end
`else
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i] <= '0;
            end
            r_psr        <= 3'b010;
            r_vsr1       <= '0;
            r_vsr2       <= '0;
            r_last_grant <= GRANT_MEM;
        end else begin
            if (w_wr_en) begin
                r_rf[w_wr_dr] <= w_wr_data;
            end
            if (w_wr_en && w_wr_setcc) begin
                r_psr <= w_psr_next;
            end
            r_vsr1       <= w_rd1;
            r_vsr2       <= w_rd2;
            r_last_grant <= w_last_next;
        end
    end

    assign alu_ready = w_grant_alu;
    assign mem_ready = w_grant_mem;
    assign psr       = r_psr;
    assign VSR1      = r_vsr1;
    assign VSR2      = r_vsr2;

endmodule

// File: doc/writeback_arb_ctrl.md
# writeback_arb_ctrl

Writeback controller for the LC-3 datapath. Arbitrates register-file writes from the execute (ALU) and memory-access (load) sources, owns the 8×16 general-purpose register file, and maintains the NZP condition code. Drives the `psr`, `VSR1` and `VSR2` signals that the writeback_out bus carries to decode/execute.

## Interface
Parameters:
- `DATA_W`, 16, register and writeback data width
- `NREGS`, 8, number of general-purpose registers; address width is log2(NREGS) = 3

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `alu_valid`  in  1  ALU writeback request
- `alu_ready`  out  1  ALU request accepted this cycle
- `alu_dr`  in  3  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `alu_setcc`  in  1  ALU write updates `psr`
- `mem_valid`  in  1  load writeback request
- `mem_ready`  out  1  load request accepted this cycle
- `mem_dr`  in  3  load destination register
- `mem_data`  in  DATA_W  load data
- `mem_setcc`  in  1  load write updates `psr`
- `sr1`  in  3  read address, port 1
- `sr2`  in  3  read address, port 2
- `psr`  out  3  condition code {N,Z,P}, registered
- `VSR1`  out  DATA_W  registered read data for `sr1`
- `VSR2`  out  DATA_W  registered read data for `sr2`

## Operation
- Handshake: a source holds `*_valid`, `*_dr`, `*_data` and `*_setcc` stable until `*_ready`=1. A transfer occurs on any cycle with valid&&ready. At most one write commits per cycle.
- Arbiter state: 1-bit `last_grant` ∈ {ALU, MEM}.
  - Only one source valid: grant that source.
  - Both valid: grant the source that is not `last_grant` (round-robin).
  - Neither valid: no grant.
  - `last_grant` updates to the granted source on each transfer; it holds when idle.
- `*_ready` is combinational: `alu_ready` = grant_alu, `mem_ready` = grant_mem. `*_ready` is never 1 while the matching `*_valid` is 0.
- Commit: `RF[dr] <= data` for the granted source.
- PSR update on commit with setcc=1:
  - N = data[DATA_W-1]; Z = (data == 0); P = !N && !Z.
  - `psr <= {N,Z,P}`. Exactly one bit is set.
  - When setcc=0, `psr` holds.
- Reads: each cycle, `VSR1 <= RF[sr1]` and `VSR2 <= RF[sr2]`. Bypass behaviour is given under Configuration.
- Same-dr requests from both sources: serialised. The later grant's value remains in the register.
- Reset: RF all 0, `psr`=3'b010, `VSR1`=`VSR2`=0, `last_grant`=MEM, so the first tie grants ALU.
  - Reset wins over a simultaneous valid. No transfer occurs and both readys are 0 while `reset`=1.
  - A request pending across reset must be re-presented by its source.

## Timing
- Write latency: commit on the rising edge where valid&&ready. The RF holds the new value from the next cycle.
- `psr` reflects a committed setcc write one cycle after the handshake cycle.
- Read latency: `VSR*` is valid 1 cycle after `sr*` is presented.
- Throughput: one write per cycle. Under continuous contention each source gets every other cycle, so neither source waits more than 1 cycle.
- No combinational path from `sr*` to `VSR*`. The only combinational outputs are `alu_ready` and `mem_ready`.

## Configuration
- Macro `WB_BYPASS_EN`:
  - Defined: when a write commits on the same edge that `VSR1`/`VSR2` samples, and `dr == sr1`/`sr2`, the output takes the new write data (write-through).
  - Undefined: `VSR*` takes the pre-write RF contents; the new value appears one cycle later.
- `psr` behaviour is identical with and without the macro.

## Test plan
- Reset, then read all registers: `VSR1`=`VSR2`=0 and `psr`=3'b010 for every `sr1`/`sr2` = 0..7.
- ALU write R3=16'h8000 with setcc=1, then `sr1`=3:
  - Next cycle `psr`=3'b100.
  - `VSR1`=16'h8000 one cycle after `sr1` is presented.
- Both sources valid for 4 cycles, ALU writing R1 with 1,2 and MEM writing R2 with 5,6, starting from reset:
  - Grants go ALU, MEM, ALU, MEM.
  - Final R1=2, R2=6.
  - Each `*_ready` stays low while the other source is granted.
- MEM write R5=16'h0000 with setcc=1, then ALU write R5=16'h0007 with setcc=0: final R5=16'h0007 and `psr`=3'b010.
- ALU write R4=16'h1234 with `sr2`=4 in the same cycle:
  - `WB_BYPASS_EN` defined: `VSR2`=16'h1234 the next cycle.
  - Undefined: `VSR2`=0 the next cycle, then 16'h1234 one cycle later.
- Assert `reset` in the same cycle as `alu_valid` for R6=16'h00FF:
  - `alu_ready`=0 and R6 remains 0.
  - First post-reset tie grants ALU.
